// File: rtl/rtc_bus_pkg.sv
// Shared types and defaults for the RTC multiplexed-bus master.
// Holds the bus-cycle state and transaction phase enums, the default
// command byte and timing, and helpers used to size the timing counter.
package rtc_bus_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      STROBE,
      HOLD,
      GAP
   } state_t;

   typedef enum logic [1:0] {
      PH_CMD,
      PH_ADDR,
      PH_DATA_WR,
      PH_DATA_RD
   } phase_t;

   localparam int         DEF_DW        = 8;
   localparam logic [7:0] DEF_CMD_XFER  = 8'hF0;
   localparam int         DEF_T_SETUP   = 2;
   localparam int         DEF_T_PULSE   = 10;
   localparam int         DEF_T_HOLD    = 2;
   localparam int         DEF_T_GAP     = 4;
   localparam int         DEF_BURST_MAX = 16;

   // Length of one complete bus cycle in clocks.
   function automatic int calc_tc(input int ts, input int tp, input int th, input int tg);
      return ts + tp + th + tg;
   endfunction

   // Longest single state, used to size the down-counter.
   function automatic int t_max(input int ts, input int tp, input int th, input int tg);
      int m;
      m = ts;
      if (tp > m) m = tp;
      if (th > m) m = th;
      if (tg > m) m = tg;
      return m;
   endfunction

endpackage

// File: rtl/rtc_bus_master_if.sv
// Request/response handshake plus RTC pad-side signals of rtc_bus_master.
// The burst_len field exists only when RTC_BURST_EN is defined.
interface rtc_bus_master_if #(
   parameter int DW = 8
`ifdef RTC_BURST_EN
   , parameter int BURST_MAX = 16
`endif
) ();

   logic          req;
   logic          wr_en;
   logic [DW-1:0] addr;
   logic [DW-1:0] wdata;
`ifdef RTC_BURST_EN
   logic [$clog2(BURST_MAX+1)-1:0] burst_len;
`endif
   logic          busy;
   logic          done;
   logic [DW-1:0] rdata;
   logic          rvalid;
   logic          cs_n;
   logic          rd_n;
   logic          wr_n;
   logic          a_d;
   logic [DW-1:0] bus_out;
   logic          bus_oe;
   logic [DW-1:0] bus_in;

   modport master (
`ifdef RTC_BURST_EN
      input  burst_len,
`endif
      input  req, wr_en, addr, wdata, bus_in,
      output busy, done, rdata, rvalid,
      output cs_n, rd_n, wr_n, a_d, bus_out, bus_oe
   );

   modport slave (
`ifdef RTC_BURST_EN
      output burst_len,
`endif
      output req, wr_en, addr, wdata, bus_in,
      input  busy, done, rdata, rvalid,
      input  cs_n, rd_n, wr_n, a_d, bus_out, bus_oe
   );

endinterface

// File: rtl/rtc_bus_cycle.sv
// Timing engine for one RTC bus cycle: SETUP -> STROBE -> HOLD -> GAP.
// A start seen in IDLE, or on the last GAP clock, chains straight into a
// new SETUP so consecutive cycles have no idle clock between them.
// All pad outputs are registered from the next-state decode.
module rtc_bus_cycle
   import rtc_bus_pkg::*;
#(
   parameter int DW      = DEF_DW,
   parameter int T_SETUP = DEF_T_SETUP,
   parameter int T_PULSE = DEF_T_PULSE,
   parameter int T_HOLD  = DEF_T_HOLD,
   parameter int T_GAP   = DEF_T_GAP
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start_i,
   input  logic          strobe_is_rd_i,
   input  logic [DW-1:0] drv_i,
   output logic          cs_n_o,
   output logic          rd_n_o,
   output logic          wr_n_o,
   output logic          bus_oe_o,
   output logic [DW-1:0] bus_out_o,
   output logic          cycle_done_o,
   output logic          strobe_last_o
);

   localparam int CW = $clog2(t_max(T_SETUP, T_PULSE, T_HOLD, T_GAP)) + 1;
   localparam logic [CW-1:0] LD_SETUP = CW'(T_SETUP - 1);
   localparam logic [CW-1:0] LD_PULSE = CW'(T_PULSE - 1);
   localparam logic [CW-1:0] LD_HOLD  = CW'(T_HOLD - 1);
   localparam logic [CW-1:0] LD_GAP   = CW'(T_GAP - 1);

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          load;
   logic          is_rd_q, is_rd_d;
   logic [DW-1:0] bus_out_q, bus_out_d;
   logic          active_d;
   logic          cs_n_q, rd_n_q, wr_n_q, bus_oe_q;

   // Next state, counter reload and cycle-level event decode.
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      load          = 1'b0;
      cycle_done_o  = 1'b0;
      strobe_last_o = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start_i) begin
               load    = 1'b1;
               state_d = SETUP;
               cnt_d   = LD_SETUP;
            end
         end
         SETUP: begin
            if (cnt_q == '0) begin
               state_d = STROBE;
               cnt_d   = LD_PULSE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         STROBE: begin
            if (cnt_q == '0) begin
               strobe_last_o = 1'b1;
               state_d       = HOLD;
               cnt_d         = LD_HOLD;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         HOLD: begin
            if (cnt_q == '0) begin
               state_d = GAP;
               cnt_d   = LD_GAP;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         GAP: begin
            if (cnt_q == '0) begin
               cycle_done_o = 1'b1;
               if (start_i) begin
                  load    = 1'b1;
                  state_d = SETUP;
                  cnt_d   = LD_SETUP;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
      is_rd_d   = load ? strobe_is_rd_i : is_rd_q;
      bus_out_d = load ? drv_i : bus_out_q;
      active_d  = (state_d == SETUP) || (state_d == STROBE) || (state_d == HOLD);
   end

   // State and counter register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Pad outputs registered from the next state so they are glitch-free.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         is_rd_q   <= 1'b0;
         bus_out_q <= '0;
         cs_n_q    <= 1'b1;
         rd_n_q    <= 1'b1;
         wr_n_q    <= 1'b1;
         bus_oe_q  <= 1'b0;
      end else begin
         is_rd_q   <= is_rd_d;
         bus_out_q <= bus_out_d;
         cs_n_q    <= !active_d;
         rd_n_q    <= !((state_d == STROBE) && is_rd_d);
         wr_n_q    <= !((state_d == STROBE) && !is_rd_d);
         // A read cycle never drives the bus, so OE and RD can't overlap.
         bus_oe_q  <= active_d && !is_rd_d;
      end
   end

   assign cs_n_o    = cs_n_q;
   assign rd_n_o    = rd_n_q;
   assign wr_n_o    = wr_n_q;
   assign bus_oe_o  = bus_oe_q;
   assign bus_out_o = bus_out_q;

endmodule

// File: rtl/rtc_bus_master.sv
// Master for the multiplexed address/data RTC bus.
// Write: ADDR, DATA, CMD.  Read: CMD, ADDR, DATA_RD.  Each step is one
// rtc_bus_cycle; this level sequences the phases and owns req/busy/done.
// Optional feature macro: RTC_BURST_EN (multi-word reads via burst_len).
module rtc_bus_master
   import rtc_bus_pkg::*;
#(
   parameter int            DW        = DEF_DW,
   parameter logic [DW-1:0] CMD_XFER  = DW'(DEF_CMD_XFER),
   parameter int            T_SETUP   = DEF_T_SETUP,
   parameter int            T_PULSE   = DEF_T_PULSE,
   parameter int            T_HOLD    = DEF_T_HOLD,
   parameter int            T_GAP     = DEF_T_GAP,
   parameter int            BURST_MAX = DEF_BURST_MAX
) (
   input  logic              clk,
   input  logic              reset,
   rtc_bus_master_if.master  bus
);

   localparam int WW = $clog2(BURST_MAX + 1);

   phase_t        phase_q, phase_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          rvalid_q, rvalid_d;
   logic          wr_q, wr_d;
   logic [DW-1:0] addr_q, addr_d;
   logic [DW-1:0] wdata_q, wdata_d;
   logic [WW-1:0] words_q, words_d;
   logic          a_d_q, a_d_d;
   logic [DW-1:0] rdata_q;
   logic [WW-1:0] req_words;

   logic          start;
   logic          strobe_is_rd;
   logic [DW-1:0] drv;
   logic          ad_next;
   logic          cyc_done;
   logic          strobe_last;
   logic          cs_n_w, rd_n_w, wr_n_w, bus_oe_w;
   logic [DW-1:0] bus_out_w;

`ifdef RTC_BURST_EN
   // Word count for a read: zero means one, anything above the maximum is clamped.
   always_comb begin
      req_words = bus.burst_len;
      if (bus.burst_len == '0) begin
         req_words = WW'(1);
      end else if (bus.burst_len > WW'(BURST_MAX)) begin
         req_words = WW'(BURST_MAX);
      end
   end
`else
   assign req_words = WW'(1);
`endif

   // Phase sequencing, handshake and the drive value for the next bus cycle.
   always_comb begin
      phase_d      = phase_q;
      busy_d       = busy_q;
      done_d       = 1'b0;
      rvalid_d     = 1'b0;
      wr_d         = wr_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      words_d      = words_q;
      start        = 1'b0;
      strobe_is_rd = 1'b0;
      drv          = '0;
      ad_next      = 1'b0;
      if (!busy_q) begin
         if (bus.req) begin
            busy_d  = 1'b1;
            wr_d    = bus.wr_en;
            addr_d  = bus.addr;
            wdata_d = bus.wdata;
            words_d = req_words;
            start   = 1'b1;
            if (bus.wr_en) begin
               phase_d = PH_ADDR;
               drv     = bus.addr;
            end else begin
               phase_d = PH_CMD;
               drv     = CMD_XFER;
            end
         end
      end else if (cyc_done) begin
         unique case (phase_q)
            PH_ADDR: begin
               start   = 1'b1;
               ad_next = 1'b1;
               if (wr_q) begin
                  phase_d = PH_DATA_WR;
                  drv     = wdata_q;
               end else begin
                  phase_d      = PH_DATA_RD;
                  strobe_is_rd = 1'b1;
               end
            end
            PH_DATA_WR: begin
               phase_d = PH_CMD;
               drv     = CMD_XFER;
               start   = 1'b1;
            end
            PH_CMD: begin
               if (wr_q) begin
                  busy_d = 1'b0;
                  done_d = 1'b1;
               end else begin
                  phase_d = PH_ADDR;
                  drv     = addr_q;
                  start   = 1'b1;
               end
            end
            PH_DATA_RD: begin
               // rvalid is issued at the end of the word's bus cycle so the
               // final word's rvalid lands together with done.
               rvalid_d = 1'b1;
               if (words_q > WW'(1)) begin
                  words_d = words_q - 1'b1;
                  addr_d  = addr_q + 1'b1;
                  phase_d = PH_ADDR;
                  drv     = addr_q + 1'b1;
                  start   = 1'b1;
               end else begin
                  busy_d = 1'b0;
                  done_d = 1'b1;
               end
            end
            default: phase_d = PH_CMD;
         endcase
      end
      a_d_d = start ? ad_next : a_d_q;
   end

   // Transaction control and handshake registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         phase_q  <= PH_CMD;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         rvalid_q <= 1'b0;
         wr_q     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         words_q  <= '0;
         a_d_q    <= 1'b0;
      end else begin
         phase_q  <= phase_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         rvalid_q <= rvalid_d;
         wr_q     <= wr_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         words_q  <= words_d;
         a_d_q    <= a_d_d;
      end
   end

   // Read data captured on the final strobe clock while the RTC still drives.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rdata_q <= '0;
      end else if (busy_q && (phase_q == PH_DATA_RD) && strobe_last) begin
         rdata_q <= bus.bus_in;
      end
   end

   rtc_bus_cycle #(
      .DW      (DW),
      .T_SETUP (T_SETUP),
      .T_PULSE (T_PULSE),
      .T_HOLD  (T_HOLD),
      .T_GAP   (T_GAP)
   ) u_cycle (
      .clk            (clk),
      .reset          (reset),
      .start_i        (start),
      .strobe_is_rd_i (strobe_is_rd),
      .drv_i          (drv),
      .cs_n_o         (cs_n_w),
      .rd_n_o         (rd_n_w),
      .wr_n_o         (wr_n_w),
      .bus_oe_o       (bus_oe_w),
      .bus_out_o      (bus_out_w),
      .cycle_done_o   (cyc_done),
      .strobe_last_o  (strobe_last)
   );

   assign bus.busy    = busy_q;
   assign bus.done    = done_q;
   assign bus.rvalid  = rvalid_q;
   assign bus.rdata   = rdata_q;
   assign bus.a_d     = a_d_q;
   assign bus.cs_n    = cs_n_w;
   assign bus.rd_n    = rd_n_w;
   assign bus.wr_n    = wr_n_w;
   assign bus.bus_oe  = bus_oe_w;
   assign bus.bus_out = bus_out_w;

endmodule
